// File: rtl/baggage_drop_ctrl.sv
// rtl/baggage_drop_ctrl.sv - baggage-drop transaction sequencer
//
// Runs one drop transaction per start request. It samples four height sensors
// each cycle into a rounded height and waits for that height to settle. It then
// compares the height with h_limit and either pulses the drop actuator for a
// fixed window or flags a rejection.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a transaction (IDLE only)
//   abort      cancel from SAMPLE/CHECK/DROP/REJECT
//   sensor1..4 raw height sensors, 0 = blocked/invalid
//   h_limit    maximum accepted height, used in CHECK
//   height_q   last registered rounded height
//   busy       high whenever not IDLE
//   drop_en    drop actuator enable
//   reject     one-cycle rejection pulse
//   done       one-cycle end-of-transaction pulse
//   status     00 none, 01 dropped, 10 rejected, 11 timeout/abort
module baggage_drop_ctrl #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 64,
  parameter int DROP_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] sensor1,
  input  logic [7:0] sensor2,
  input  logic [7:0] sensor3,
  input  logic [7:0] sensor4,
  input  logic [7:0] h_limit,
  output logic [7:0] height_q,
  output logic       busy,
  output logic       drop_en,
  output logic       reject,
  output logic       done,
  output logic [1:0] status
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DROP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    CHECK,
    DROP,
    REJECT,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] stab_cnt, stab_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic [DW-1:0] drop_cnt, drop_cnt_n;
  logic [7:0]    height_n;
  logic [1:0]    status_n;
  logic          busy_n, drop_en_n, reject_n, done_n;
  logic [7:0]    h_new;
  logic          same;

  // Rounded height. Sums are widened before rounding so that saturated
  // sensors (255) never wrap; a blocked sensor drops its whole pair.
  always_comb begin
    h_new = 8'd0;
    if (sensor1 == 8'd0 || sensor3 == 8'd0)
      h_new = 8'(({1'b0, sensor2} + {1'b0, sensor4} + 9'd1) >> 1);
    else if (sensor2 == 8'd0 || sensor4 == 8'd0)
      h_new = 8'(({1'b0, sensor1} + {1'b0, sensor3} + 9'd1) >> 1);
    else
      h_new = 8'(({2'b0, sensor1} + {2'b0, sensor2} + {2'b0, sensor3}
                  + {2'b0, sensor4} + 10'd2) >> 2);
  end

  assign same = (h_new == height_q);

  always_comb begin
    state_n    = state;
    height_n   = height_q;
    stab_n     = stab_cnt;
    tmo_n      = tmo_cnt;
    drop_cnt_n = drop_cnt;
    status_n   = status;

    case (state)
      IDLE: begin
        if (start) begin
          state_n  = SAMPLE;
          height_n = h_new;
          stab_n   = '0;
          tmo_n    = '0;
          status_n = 2'b00;
        end
      end
      SAMPLE: begin
        height_n = h_new;
        tmo_n    = tmo_cnt + 1'b1;
        stab_n   = same ? stab_cnt + 1'b1 : '0;
        // Stability wins over timeout when both land on the same cycle.
        if (same && stab_cnt == SW'(STABLE_CYCLES - 1)) begin
          state_n = CHECK;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          state_n  = REJECT;
          status_n = 2'b11;
        end
      end
      CHECK: begin
        if (height_q != 8'd0 && height_q <= h_limit) begin
          state_n    = DROP;
          status_n   = 2'b01;
          drop_cnt_n = '0;
        end else begin
          state_n  = REJECT;
          status_n = 2'b10;
        end
      end
      DROP: begin
        if (drop_cnt == DW'(DROP_CYCLES - 1))
          state_n = DONE;
        else
          drop_cnt_n = drop_cnt + 1'b1;
      end
      REJECT:  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Abort overrides any transition chosen above.
    if (abort && (state == SAMPLE || state == CHECK || state == DROP || state == REJECT)) begin
      state_n  = DONE;
      status_n = 2'b11;
    end

    // Outputs are registered copies of the next state's decode.
    busy_n    = (state_n != IDLE);
    drop_en_n = (state_n == DROP);
    reject_n  = (state_n == REJECT);
    done_n    = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      height_q <= 8'd0;
      stab_cnt <= '0;
      tmo_cnt  <= '0;
      drop_cnt <= '0;
      status   <= 2'b00;
      busy     <= 1'b0;
      drop_en  <= 1'b0;
      reject   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      height_q <= height_n;
      stab_cnt <= stab_n;
      tmo_cnt  <= tmo_n;
      drop_cnt <= drop_cnt_n;
      status   <= status_n;
      busy     <= busy_n;
      drop_en  <= drop_en_n;
      reject   <= reject_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// tb/tb_baggage_drop_ctrl.sv - self-checking bench for baggage_drop_ctrl
module tb_baggage_drop_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] sensor1 = 8'd0, sensor2 = 8'd0, sensor3 = 8'd0, sensor4 = 8'd0;
  logic [7:0] h_limit = 8'd0;
  logic [7:0] height_q;
  logic       busy, drop_en, reject, done;
  logic [1:0] status;

  int tests = 0;
  int fails = 0;

  baggage_drop_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
    .h_limit(h_limit), .height_q(height_q), .busy(busy), .drop_en(drop_en),
    .reject(reject), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s1, s2, s3, s4, lim, exp_h;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered just after a rising edge. Drives start so that the next edge (E0)
  // takes it, then observes each cycle at the falling edge; n=k is after Ek.
  task automatic run_vec(input int i);
    int first_drop, dcnt, rcnt, done_at;
    first_drop = -1; dcnt = 0; rcnt = 0; done_at = -1;
    sensor1 = vecs[i].s1; sensor2 = vecs[i].s2;
    sensor3 = vecs[i].s3; sensor4 = vecs[i].s4;
    h_limit = vecs[i].lim;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 40 && done_at < 0; n++) begin
      @(negedge clk);
      if (n == 0) chk($sformatf("v%0d height", i), height_q, vecs[i].exp_h);
      if (drop_en) begin
        if (first_drop < 0) first_drop = n;
        dcnt++;
      end
      if (reject) rcnt++;
      if (done) done_at = n;
    end
    chk($sformatf("v%0d status", i), status, vecs[i].exp_st);
    if (vecs[i].exp_st == 2'b01) begin
      chk($sformatf("v%0d drop_start", i), first_drop, 5);
      chk($sformatf("v%0d drop_len", i), dcnt, 8);
      chk($sformatf("v%0d reject_cnt", i), rcnt, 0);
      chk($sformatf("v%0d done_at", i), done_at, 13);
    end else begin
      chk($sformatf("v%0d drop_len", i), dcnt, 0);
      chk($sformatf("v%0d reject_cnt", i), rcnt, 1);
      chk($sformatf("v%0d done_at", i), done_at, 6);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d idle_busy", i), busy, 0);
  endtask

  initial begin
    int rej_at, done_at;

    vecs[0] = '{8'd10,  8'd20,  8'd30,  8'd40,  8'd30,  8'd25,  2'b01};
    vecs[1] = '{8'd0,   8'd7,   8'd9,   8'd8,   8'd255, 8'd8,   2'b01};
    vecs[2] = '{8'd5,   8'd0,   8'd6,   8'd9,   8'd5,   8'd6,   2'b10};
    vecs[3] = '{8'd1,   8'd1,   8'd1,   8'd2,   8'd1,   8'd1,   2'b01};
    vecs[4] = '{8'd1,   8'd1,   8'd2,   8'd2,   8'd1,   8'd2,   2'b10};
    vecs[5] = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd150, 8'd200, 2'b10};
    vecs[6] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd255, 8'd0,   2'b10};
    vecs[7] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 2'b01};
    vecs[8] = '{8'd0,   8'd255, 8'd0,   8'd255, 8'd255, 8'd255, 2'b01};
    vecs[9] = '{8'd255, 8'd0,   8'd255, 8'd7,   8'd254, 8'd255, 2'b10};

    #1 rst = 1'b1;
    #1;
    chk("reset busy", busy, 0);
    chk("reset drop_en", drop_en, 0);
    chk("reset status", status, 0);
    chk("reset height", height_q, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // abort while idle does nothing
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("idle abort busy", busy, 0);
    chk("idle abort status", status, 2'b10);
    @(posedge clk); #1;

    // sensor2 alternates 40/44: height alternates 40/41 and never settles
    sensor1 = 8'd40; sensor2 = 8'd40; sensor3 = 8'd40; sensor4 = 8'd40;
    h_limit = 8'd255;
    start = 1'b1;
    rej_at = -1; done_at = -1;
    for (int n = 0; n < 80 && done_at < 0; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      sensor2 = (sensor2 == 8'd40) ? 8'd44 : 8'd40;
      @(negedge clk);
      if (reject && rej_at < 0) rej_at = n;
      if (done) done_at = n;
    end
    chk("timeout reject_at", rej_at, 64);
    chk("timeout done_at", done_at, 65);
    chk("timeout status", status, 2'b11);
    sensor2 = 8'd20; sensor1 = 8'd10; sensor3 = 8'd30; sensor4 = 8'd40;
    h_limit = 8'd30;
    @(posedge clk); #1;

    // abort in DROP cycle 3, with an ignored start in DROP cycle 2
    start = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (n == 0) start = 1'b0;
      if (n == 6) start = 1'b1;
      if (n == 7) begin start = 1'b0; abort = 1'b1; end
      if (n == 8) abort = 1'b0;
      @(negedge clk);
      if (n == 7) chk("abort pre drop_en", drop_en, 1);
      if (n == 8) begin
        chk("abort drop_en", drop_en, 0);
        chk("abort done", done, 1);
        chk("abort status", status, 2'b11);
      end
      if (n == 9)  chk("abort idle busy", busy, 0);
      if (n == 11) chk("start not queued", busy, 0);
    end
    @(posedge clk); #1;

    // asynchronous reset in the middle of DROP
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("pre-reset drop_en", drop_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst drop_en", drop_en, 0);
    chk("async rst busy", busy, 0);
    chk("async rst status", status, 0);
    chk("async rst height", height_q, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
